// File: rtl/multi_timer_pkg.sv
// multi_timer_pkg: shared types and constants for the multi-channel down-timer.
// Contents: per-channel FSM state encoding and mode encoding.
// Imported by timer_channel and multi_timer.
package multi_timer_pkg;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_RUN  = 2'd1,
    CH_HOLD = 2'd2
  } ch_state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/multi_timer_channel.sv
// timer_channel: one programmable down-counter with IDLE/RUN/HOLD control.
// Ports: clk_i/rst_ni (async active-low); tick (shared prescaler strobe);
//        start/stop strobes, hold level, mode/reload (sampled on start); count, busy, done outputs.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             mode,
  input  logic [WIDTH-1:0] reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  ch_state_e        state;
  logic             mode_l;
  logic [WIDTH-1:0] reload_l;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= CH_IDLE;
      count    <= '1;
      mode_l   <= MODE_ONESHOT;
      reload_l <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // Start wins over stop/hold and restarts from any state.
        state    <= CH_RUN;
        count    <= reload;
        mode_l   <= mode;
        reload_l <= reload;
      end else begin
        unique case (state)
          CH_RUN: begin
            if (stop) begin
              state <= CH_IDLE;
            end else begin
              // Hold takes effect from the next cycle: the tick seen in the
              // cycle hold rises is still applied, and the tick seen in the
              // cycle hold falls (still HOLD) is dropped, so a hold of N
              // cycles costs exactly N cycles of counting.
              if (hold) state <= CH_HOLD;
              if (tick) begin
                if (count != '0) begin
                  count <= count - 1'b1;
                end else begin
                  done <= 1'b1;
                  if (mode_l == MODE_PERIODIC) begin
                    count <= reload_l;
                  end else begin
                    // Later assignment overrides a pending move to HOLD.
                    state <= CH_IDLE;
                  end
                end
              end
            end
          end
          CH_HOLD: begin
            if (stop) begin
              state <= CH_IDLE;
            end else if (!hold) begin
              state <= CH_RUN;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy = (state != CH_IDLE);

endmodule

// File: rtl/multi_timer.sv
// multi_timer: NUM_CH independent down-timers sharing one free-running prescaler.
// Ports: clk_i/rst_ni (async active-low); presc_i divide value; per-channel start/stop/hold/mode/reload;
//        count_o/busy_o/done_o per channel. Optional MULTI_TIMER_IRQ_EN adds irq_clr_i and irq_o.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NUM_CH  = 4,
  parameter int PRESC_W = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [PRESC_W-1:0]             presc_i,
  input  logic [NUM_CH-1:0]              start_i,
  input  logic [NUM_CH-1:0]              stop_i,
  input  logic [NUM_CH-1:0]              hold_i,
  input  logic [NUM_CH-1:0]              mode_i,
  input  logic [NUM_CH-1:0][WIDTH-1:0]   reload_i,
  output logic [NUM_CH-1:0][WIDTH-1:0]   count_o,
  output logic [NUM_CH-1:0]              busy_o,
  output logic [NUM_CH-1:0]              done_o
`ifdef MULTI_TIMER_IRQ_EN
  ,
  input  logic [NUM_CH-1:0]              irq_clr_i,
  output logic                           irq_o
`endif
);

  // Prescaler is never realigned by a channel start; presc_i is only picked
  // up when the count reloads on a tick.
  logic [PRESC_W-1:0] presc_cnt;
  logic               tick;

  assign tick = (presc_cnt == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= presc_i;
    end else begin
      presc_cnt <= presc_cnt - 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timer_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .tick   (tick),
      .start  (start_i[g]),
      .stop   (stop_i[g]),
      .hold   (hold_i[g]),
      .mode   (mode_i[g]),
      .reload (reload_i[g]),
      .count  (count_o[g]),
      .busy   (busy_o[g]),
      .done   (done_o[g])
    );
  end

`ifdef MULTI_TIMER_IRQ_EN
  logic [NUM_CH-1:0] irq_status;

  // Sticky status: a done in the same cycle as a clear keeps the bit set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_status <= '0;
      irq_o      <= 1'b0;
    end else begin
      irq_status <= (irq_status & ~irq_clr_i) | done_o;
      irq_o      <= |irq_status;
    end
  end
`endif

endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: directed plus randomized bench for multi_timer with a behavioural reference model.
// Ports: none (top-level bench); drives all multi_timer inputs, compares all outputs each cycle.
// Builds with or without MULTI_TIMER_IRQ_EN.
module tb_multi_timer;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int PW = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [PW-1:0]       presc;
  logic [N-1:0]        start, stop, hold, mode;
  logic [N-1:0][W-1:0] reload;
  logic [N-1:0][W-1:0] count;
  logic [N-1:0]        busy, done;
`ifdef MULTI_TIMER_IRQ_EN
  logic [N-1:0]        irq_clr;
  logic                irq;
`endif

  always #5 clk = ~clk;

  multi_timer #(.WIDTH(W), .NUM_CH(N), .PRESC_W(PW)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .presc_i  (presc),
    .start_i  (start),
    .stop_i   (stop),
    .hold_i   (hold),
    .mode_i   (mode),
    .reload_i (reload),
    .count_o  (count),
    .busy_o   (busy),
    .done_o   (done)
`ifdef MULTI_TIMER_IRQ_EN
    ,
    .irq_clr_i(irq_clr),
    .irq_o    (irq)
`endif
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model: cycles-to-next-tick counter plus, per channel, the
  // remaining count and whether the timer is active and/or paused.
  int m_pc;
  int m_cnt[N];
  int m_rel[N];
  bit m_per[N];
  bit m_act[N];
  bit m_pause[N];
  bit m_done[N];
  bit m_stat[N];
  bit m_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = 0;
    m_irq = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 65535; m_rel[i] = 0; m_per[i] = 1'b0;
      m_act[i] = 1'b0;  m_pause[i] = 1'b0; m_done[i] = 1'b0; m_stat[i] = 1'b0;
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit tick;
    bit any_stat;
    tick = (m_pc == 0);
    m_pc = tick ? int'(presc) : m_pc - 1;
    any_stat = 1'b0;
    for (int i = 0; i < N; i++) any_stat |= m_stat[i];
    m_irq = any_stat;
    for (int i = 0; i < N; i++) begin
`ifdef MULTI_TIMER_IRQ_EN
      m_stat[i] = (m_stat[i] & ~irq_clr[i]) | m_done[i];
`endif
      m_done[i] = 1'b0;
      if (start[i]) begin
        m_rel[i] = int'(reload[i]); m_per[i] = mode[i];
        m_cnt[i] = int'(reload[i]); m_act[i] = 1'b1; m_pause[i] = 1'b0;
      end else if (m_act[i]) begin
        if (stop[i]) begin
          m_act[i] = 1'b0; m_pause[i] = 1'b0;
        end else if (m_pause[i]) begin
          if (!hold[i]) m_pause[i] = 1'b0;
        end else begin
          if (tick) begin
            if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
            else begin
              m_done[i] = 1'b1;
              if (m_per[i]) m_cnt[i] = m_rel[i];
              else m_act[i] = 1'b0;
            end
          end
          if (hold[i] && m_act[i]) m_pause[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("count[%0d]", i), 32'(count[i]), 32'(m_cnt[i]));
      chk($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(m_act[i]));
      chk($sformatf("done[%0d]", i), 32'(done[i]), 32'(m_done[i]));
    end
`ifdef MULTI_TIMER_IRQ_EN
    chk("irq", 32'(irq), 32'(m_irq));
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic clear_strobes();
    start = '0; stop = '0;
`ifdef MULTI_TIMER_IRQ_EN
    irq_clr = '0;
`endif
  endtask

  // Asserts reset between edges and checks outputs before any clock arrives.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    clear_strobes();
    hold = '0;
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin : stim
    int k, nd;
    bit busy_ok;
    rst_n = 1'b0; presc = '0; hold = '0; mode = '0; reload = '0;
    clear_strobes();
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    cycle();
    chk("reset_count0", 32'(count[0]), 32'hFFFF);

    // One-shot, reload 3, tick every cycle.
    reload[0] = 16'd3; mode[0] = 1'b0; start[0] = 1'b1;
    cycle(); clear_strobes();
    chk("oneshot_first", 32'(count[0]), 32'd3);
    k = 1;
    while (!done[0] && k < 50) begin cycle(); k++; end
    chk("oneshot_latency", k, 5);
    chk("oneshot_busy_fall", 32'(busy[0]), 0);
    cycle();
    chk("oneshot_stays0", 32'(count[0]), 0);

    // Periodic, presc 2, reload 1: period 6 cycles.
    presc = 8'd2; reload[1] = 16'd1; mode[1] = 1'b1; start[1] = 1'b1;
    cycle(); clear_strobes();
    nd = 0; busy_ok = 1'b1;
    repeat (30) begin cycle(); nd += int'(done[1]); if (!busy[1]) busy_ok = 1'b0; end
    chk("periodic_pulses", nd, 5);
    chk("periodic_busy", 32'(busy_ok), 1);
    stop[1] = 1'b1; cycle(); clear_strobes();

    // Hold 7 cycles delays expiry by exactly 7.
    presc = 8'd0;
    repeat (3) cycle();
    reload[2] = 16'd10; mode[2] = 1'b0; start[2] = 1'b1;
    cycle(); clear_strobes();
    k = 1;
    repeat (2) begin cycle(); k++; end
    hold[2] = 1'b1;
    repeat (7) begin cycle(); k++; end
    hold[2] = 1'b0;
    while (!done[2] && k < 60) begin cycle(); k++; end
    chk("hold_latency", k, 19);

    // Stop at count 4: stays 4, no done.
    start[2] = 1'b1;
    cycle(); clear_strobes();
    k = 0;
    while (count[2] != 16'd4 && k < 40) begin cycle(); k++; end
    chk("stop_reach4", 32'(count[2]), 4);
    stop[2] = 1'b1;
    cycle(); clear_strobes();
    chk("stop_count", 32'(count[2]), 4);
    chk("stop_busy", 32'(busy[2]), 0);
    nd = 0;
    repeat (15) begin cycle(); nd += int'(done[2]); end
    chk("stop_nodone", nd, 0);

    // Start and stop together restarts.
    reload[3] = 16'd8; start[3] = 1'b1;
    cycle(); clear_strobes();
    repeat (3) cycle();
    reload[3] = 16'd6; start[3] = 1'b1; stop[3] = 1'b1;
    cycle(); clear_strobes();
    chk("startstop_count", 32'(count[3]), 6);
    chk("startstop_busy", 32'(busy[3]), 1);
    stop[3] = 1'b1; cycle(); clear_strobes();

    // Start on the expiry tick suppresses done.
    reload[0] = 16'd2; start[0] = 1'b1;
    cycle(); clear_strobes();
    k = 0;
    while (count[0] != 16'd0 && k < 20) begin cycle(); k++; end
    reload[0] = 16'd5; start[0] = 1'b1;
    cycle(); clear_strobes();
    chk("restart_expiry_done", 32'(done[0]), 0);
    chk("restart_expiry_count", 32'(count[0]), 5);

    // Periodic reload 0: done every tick.
    reload[1] = 16'd0; mode[1] = 1'b1; start[1] = 1'b1;
    cycle(); clear_strobes();
    nd = 0;
    repeat (10) begin cycle(); nd += int'(done[1]); end
    chk("periodic0_pulses", nd, 10);
    stop = '1; cycle(); clear_strobes();

    // Randomized traffic, with an asynchronous reset in the middle.
    for (int c = 0; c < 1500; c++) begin
      if (c % 200 == 0) presc = 8'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) begin
        start[i]  = ($urandom_range(0, 15) == 0);
        stop[i]   = ($urandom_range(0, 23) == 0);
        if ($urandom_range(0, 7) == 0) hold[i] = ~hold[i];
        mode[i]   = 1'($urandom_range(0, 1));
        reload[i] = 16'($urandom_range(0, 11));
`ifdef MULTI_TIMER_IRQ_EN
        irq_clr[i] = ($urandom_range(0, 5) == 0);
`endif
      end
      if (c == 700) async_reset();
      else cycle();
    end
    clear_strobes();
    hold = '0;
    repeat (5) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
Name: multi_timer

Overview:
Multi-channel programmable down-timer, generalising the single load/decrement counter. NUM_CH independent channels share one prescaler tick. Each channel supports one-shot and periodic (auto-reload) modes, start/stop/hold control and a one-cycle expiry pulse. It sits between the sequencing FSMs (traffic phases, blink rates) and the clock, replacing per-phase counter instances.

Parameters:
WIDTH, 16, bit width of each channel counter and reload value
NUM_CH, 4, number of independent timer channels (>=1)
PRESC_W, 8, bit width of the shared prescaler

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
presc_i  input  PRESC_W  prescaler divide value; a tick occurs every presc_i+1 cycles
start_i  input  NUM_CH  per-channel start/restart strobe
stop_i  input  NUM_CH  per-channel stop strobe
hold_i  input  NUM_CH  per-channel pause level
mode_i  input  NUM_CH  per-channel mode; 0 = one-shot, 1 = periodic; sampled at start
reload_i  input  NUM_CH x WIDTH (packed [NUM_CH-1:0][WIDTH-1:0])  per-channel reload value; sampled at start
count_o  output  NUM_CH x WIDTH  current count per channel
busy_o  output  NUM_CH  channel in RUN or HOLD
done_o  output  NUM_CH  one-cycle expiry pulse

Behaviour:
- Reset is asynchronous, active-low; clock is clk_i.
- Reset values: count_o all '1 per channel; busy_o 0; done_o 0; prescaler count 0; all channels IDLE; latched mode 0; latched reload 0.
- Prescaler:
  - tick = (presc_cnt == 0).
  - On tick, presc_cnt <= presc_i; otherwise presc_cnt decrements.
  - presc_i = 0 gives a tick every cycle.
  - presc_i changes take effect at the next reload.
- Per-channel FSM states: IDLE, RUN, HOLD.
  - Any state, start_i = 1: latch reload_i and mode_i, count <= reload_i, go to RUN. Start has priority over stop and hold in the same cycle. Restart while RUN/HOLD is allowed.
  - RUN/HOLD, stop_i = 1 (no start): go to IDLE; count holds its value; no done.
  - RUN, hold_i = 1: go to HOLD. HOLD, hold_i = 0: go to RUN. Ticks are ignored in HOLD.
  - RUN, tick, count != 0: count decrements.
  - RUN, tick, count == 0: done_o = 1 in the next cycle.
    - Periodic: count <= latched reload; stays in RUN.
    - One-shot: go to IDLE; count stays 0.
- Latency:
  - Start at cycle n gives count_o = reload and busy_o = 1 at n+1.
  - Expiry period is (reload+1)*(presc_i+1) cycles, with prescaler phase free-running (not realigned at start).
- Reload 0: one-shot expires on the first tick after start. Periodic pulses done_o on every tick.
- Counter arithmetic is WIDTH-bit unsigned; it never wraps below 0 because expiry intercepts it.
- mode_i and reload_i changes mid-run have no effect until the next start.
- Reset mid-operation: all state returns to reset values immediately; no done pulse.

Optional Feature:
- Macro: MULTI_TIMER_IRQ_EN.
- Defined:
  - Adds ports irq_clr_i (input, NUM_CH) and irq_o (output, 1).
  - Per-channel sticky status bit is set by done, cleared by irq_clr_i; set wins on collision. Status resets to 0.
  - irq_o = OR of status bits, registered (one cycle after status).
- Undefined: ports absent; no status logic.

Decomposition:
- Package multi_timer_pkg:
  - enum ch_state_e {CH_IDLE, CH_RUN, CH_HOLD};
  - constants MODE_ONESHOT = 1'b0, MODE_PERIODIC = 1'b1.
- Sub-module timer_channel (parameter WIDTH):
  - one FSM + counter;
  - inputs tick, start, stop, hold, mode, reload;
  - outputs count, busy, done.
- Top instantiates NUM_CH channels in a generate loop and owns the prescaler (and the IRQ logic when enabled).

Test Plan:
- Reset check: after rst_ni release, count_o = all 0xFFFF, busy_o = 0, done_o = 0. Then pulse rst_ni low mid-run -> outputs return to reset values asynchronously.
- One-shot: presc_i = 0, ch0 reload = 3, start at cycle 0.
  - count 3, 2, 1, 0 on cycles 1-4;
  - done_o[0] pulses at cycle 5;
  - busy_o[0] falls at cycle 5;
  - count stays 0.
- Periodic: presc_i = 2, ch1 reload = 1, mode = 1 -> done_o[1] pulses every 6 cycles over 5 periods; busy stays 1.
- Hold/stop:
  - ch2 reload = 10, hold_i high for 7 cycles mid-count -> count frozen; expiry delayed by exactly 7 cycles.
  - stop at count 4 -> IDLE, count stays 4, no done.
- Collisions:
  - start and stop in the same cycle -> restart to reload.
  - start on the expiry tick -> reload, no done pulse.
  - periodic reload 0 -> done_o every tick.
- MULTI_TIMER_IRQ_EN:
  - done sets status; irq_o rises one cycle later.
  - irq_clr_i coincident with a new done keeps status set; a lone clear drops irq_o.
